// File: rtl/seq_rotator_pkg.sv
// -----------------------------------------------------------------------------
// seq_rotator_pkg
//   Shared definitions for the multi-cycle right shift/rotate unit.
//   - MODE_ROR / MODE_SRL : operation select encodings, also used by the ALU
//                           opcode decoder when it steers ROR/SRL here.
//   - state_e             : controller states.
//   - WIDTH_DEF/AMT_W_DEF : default data and shift-amount widths.
// -----------------------------------------------------------------------------
package seq_rotator_pkg;

    localparam int WIDTH_DEF = 16;
    localparam int AMT_W_DEF = 4;

    localparam logic MODE_ROR = 1'b0;
    localparam logic MODE_SRL = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage : seq_rotator_pkg

// File: rtl/seq_rotator_rot_step.sv
// -----------------------------------------------------------------------------
// rot_step
//   Combinational single-bit right step.
//   Ports:
//     data_i  [WIDTH-1:0]  current working value
//     mode_i               MODE_ROR: LSB wraps to MSB; MODE_SRL: zero fills MSB
//     data_o  [WIDTH-1:0]  value after one right step
// -----------------------------------------------------------------------------
module rot_step
    import seq_rotator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
) (
    input  logic [WIDTH-1:0] data_i,
    input  logic             mode_i,
    output logic [WIDTH-1:0] data_o
);

    logic fill_bit;

    assign fill_bit = (mode_i == MODE_SRL) ? 1'b0 : data_i[0];
    assign data_o   = {fill_bit, data_i[WIDTH-1:1]};

endmodule : rot_step

// File: rtl/seq_rotator.sv
// -----------------------------------------------------------------------------
// seq_rotator
//   Multi-cycle ROR / SRL unit, one bit position per clock, Start/Done
//   handshake. Operands are captured when Start is accepted in IDLE, so the
//   inputs are free to change while the operation runs.
//   Ports:
//     clk      rising-edge clock
//     rst      asynchronous active-high reset; clears state and all registers
//     Start    request, sampled only in IDLE
//     Rot_In   operand (captured on accept)
//     Rot_Val  shift/rotate amount N (captured on accept)
//     Mode     MODE_ROR / MODE_SRL (captured on accept)
//     Busy     high whenever the controller is not in IDLE
//     Done     one-cycle completion pulse
//     Rot_Out  registered result, updated only on entry to DONE
//   Timing: accept at end of cycle 0 -> Busy in cycles 1..N+1, Done in N+1.
// -----------------------------------------------------------------------------
module seq_rotator
    import seq_rotator_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int AMT_W = AMT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             Start,
    input  logic [WIDTH-1:0] Rot_In,
    input  logic [AMT_W-1:0] Rot_Val,
    input  logic             Mode,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] Rot_Out
);

    state_e             state_q,   state_d;
    logic [WIDTH-1:0]   work_q,    work_d;
    logic [AMT_W-1:0]   cnt_q,     cnt_d;
    logic               mode_q,    mode_d;
    logic [WIDTH-1:0]   rot_out_q, rot_out_d;

    logic [WIDTH-1:0]   step_data;

    rot_step #(
        .WIDTH (WIDTH)
    ) u_rot_step (
        .data_i (work_q),
        .mode_i (mode_q),
        .data_o (step_data)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            cnt_q     <= '0;
            mode_q    <= MODE_ROR;
            rot_out_q <= '0;
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            cnt_q     <= cnt_d;
            mode_q    <= mode_d;
            rot_out_q <= rot_out_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        cnt_d     = cnt_q;
        mode_d    = mode_q;
        rot_out_d = rot_out_q;

        unique case (state_q)
            IDLE: begin
                if (Start) begin
                    work_d = Rot_In;
                    cnt_d  = Rot_Val;
                    mode_d = Mode;
                    if (Rot_Val != '0) begin
                        state_d = RUN;
                    end else begin
                        // Zero amount: result is the operand itself, skip RUN.
                        state_d   = DONE;
                        rot_out_d = Rot_In;
                    end
                end
            end

            RUN: begin
                work_d = step_data;
                cnt_d  = cnt_q - AMT_W'(1);
                // RUN is only entered with a non-zero count, so the last step
                // is the one taken while count is 1; no underflow is possible.
                if (cnt_q == AMT_W'(1)) begin
                    state_d   = DONE;
                    rot_out_d = step_data;
                end
            end

            DONE: begin
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign Busy    = (state_q != IDLE);
    assign Done    = (state_q == DONE);
    assign Rot_Out = rot_out_q;

endmodule : seq_rotator

// File: tb/tb_seq_rotator.sv
// -----------------------------------------------------------------------------
// tb_seq_rotator
//   Directed-vector bench for seq_rotator. Cycle numbering: cycle 0 is the
//   cycle in which Start is presented; outputs are sampled 1 time unit after
//   each rising edge.
// -----------------------------------------------------------------------------
module tb_seq_rotator;

    logic        clk = 1'b0;
    logic        rst;
    logic        Start;
    logic [15:0] Rot_In;
    logic [3:0]  Rot_Val;
    logic        Mode;
    logic        Busy;
    logic        Done;
    logic [15:0] Rot_Out;

    int          n_vec = 0;
    int          n_err = 0;
    logic [15:0] last_out;

    seq_rotator dut (
        .clk     (clk),
        .rst     (rst),
        .Start   (Start),
        .Rot_In  (Rot_In),
        .Rot_Val (Rot_Val),
        .Mode    (Mode),
        .Busy    (Busy),
        .Done    (Done),
        .Rot_Out (Rot_Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Checks Busy, Done and Rot_Out for one cycle of a single operation.
    task automatic check_cycle(input string tag, input int c, input int done_c,
                               input int b_from, input int b_to,
                               input logic [15:0] old_v, input logic [15:0] new_v);
        logic exp_busy;
        logic exp_done;
        logic [15:0] exp_out;
        exp_busy = (c >= b_from) && (c <= b_to);
        exp_done = (c == done_c);
        exp_out  = (c >= done_c) ? new_v : old_v;
        chk($sformatf("%s busy c%0d", tag, c), {31'b0, Busy}, {31'b0, exp_busy});
        chk($sformatf("%s done c%0d", tag, c), {31'b0, Done}, {31'b0, exp_done});
        chk($sformatf("%s out c%0d", tag, c), {16'b0, Rot_Out}, {16'b0, exp_out});
    endtask

    // One isolated operation; inputs are scrambled right after accept.
    task automatic run_op(input string tag, input logic [15:0] din, input logic [3:0] n,
                          input logic mode, input logic [15:0] exp);
        Rot_In  = din;
        Rot_Val = n;
        Mode    = mode;
        Start   = 1'b1;
        step();
        Start   = 1'b0;
        Rot_In  = ~din;
        Rot_Val = ~n;
        Mode    = ~mode;
        for (int c = 1; c <= int'(n) + 3; c++) begin
            check_cycle(tag, c, int'(n) + 1, 1, int'(n) + 1, last_out, exp);
            step();
        end
        last_out = exp;
    endtask

    initial begin
        rst     = 1'b1;
        Start   = 1'b0;
        Rot_In  = 16'h0000;
        Rot_Val = 4'd0;
        Mode    = 1'b0;
        last_out = 16'h0000;

        step();
        step();
        chk("reset busy", {31'b0, Busy}, 32'd0);
        chk("reset done", {31'b0, Done}, 32'd0);
        chk("reset out", {16'b0, Rot_Out}, 32'd0);
        rst = 1'b0;
        step();

        run_op("ror4",  16'h1234, 4'd4,  1'b0, 16'h4123);
        run_op("srl15", 16'h8001, 4'd15, 1'b1, 16'h0001);
        run_op("ror1",  16'h8001, 4'd1,  1'b0, 16'hC000);
        run_op("n0",    16'hBEEF, 4'd0,  1'b0, 16'hBEEF);

        // Start pulses while busy are ignored and never queued.
        Rot_In  = 16'h000F;
        Rot_Val = 4'd3;
        Mode    = 1'b0;
        Start   = 1'b1;
        step();
        for (int c = 1; c <= 7; c++) begin
            if (c <= 4) begin
                Start   = 1'b1;
                Rot_In  = 16'hFFFF;
                Rot_Val = 4'd1;
                Mode    = c[0];
            end else begin
                Start   = 1'b0;
            end
            check_cycle("ign", c, 4, 1, 4, last_out, 16'hE001);
            step();
        end
        last_out = 16'hE001;

        // Asynchronous reset mid-operation.
        Rot_In  = 16'h00F0;
        Rot_Val = 4'd8;
        Mode    = 1'b1;
        Start   = 1'b1;
        step();
        Start   = 1'b0;
        for (int c = 1; c <= 2; c++) begin
            check_cycle("pre_rst", c, 99, 1, 99, last_out, last_out);
            step();
        end
        rst = 1'b1;
        #1;
        chk("async rst busy", {31'b0, Busy}, 32'd0);
        chk("async rst done", {31'b0, Done}, 32'd0);
        chk("async rst out", {16'b0, Rot_Out}, 32'd0);
        step();
        rst = 1'b0;
        last_out = 16'h0000;
        for (int c = 4; c <= 14; c++) begin
            check_cycle("post_rst", c, 99, 1, 0, last_out, last_out);
            step();
        end
        run_op("fresh", 16'h0001, 4'd1, 1'b0, 16'h8000);

        // Back-to-back with Start held high: A (SRL N=1) then B (ROR N=4).
        Rot_In  = 16'h0002;
        Rot_Val = 4'd1;
        Mode    = 1'b1;
        Start   = 1'b1;
        step();
        Rot_In  = 16'h00F0;
        Rot_Val = 4'd4;
        Mode    = 1'b0;
        for (int c = 1; c <= 10; c++) begin
            logic        eb;
            logic        ed;
            logic [15:0] eo;
            if (c == 8) Start = 1'b0;
            eb = (c >= 1 && c <= 2) || (c >= 4 && c <= 8);
            ed = (c == 2) || (c == 8);
            eo = (c < 2) ? last_out : ((c < 8) ? 16'h0001 : 16'h000F);
            chk($sformatf("b2b busy c%0d", c), {31'b0, Busy}, {31'b0, eb});
            chk($sformatf("b2b done c%0d", c), {31'b0, Done}, {31'b0, ed});
            chk($sformatf("b2b out c%0d", c), {16'b0, Rot_Out}, {16'b0, eo});
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_seq_rotator
